// File: rtl/muladd_pkg.sv
// rtl/muladd_pkg.sv - shared widths, state type and constants for the multiply-add inverse divider
package muladd_pkg;

    localparam int unsigned DIVIDEND_W = 16;
    localparam int unsigned DIVISOR_W  = 8;
    localparam int unsigned CNT_W      = $clog2(DIVIDEND_W);

    // Quotient reported for a zero divisor
    localparam logic [DIVIDEND_W-1:0] DBZ_QUOTIENT = '1;

    // Last iteration index; the BUSY->DONE transition happens on this count
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIVIDEND_W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one restoring-division iteration: shift in a dividend bit, trial-subtract the divisor
module div_step
    import muladd_pkg::*;
(
    input  logic [DIVISOR_W:0]   rem_i,
    input  logic                 bit_i,
    input  logic [DIVISOR_W-1:0] divisor_i,
    output logic [DIVISOR_W:0]   rem_o,
    output logic                 q_bit_o
);

    localparam int unsigned RW = DIVISOR_W + 1;

    // Full-width shift so the compare sees every bit of the partial remainder
    logic [DIVISOR_W+1:0] shifted;
    logic [DIVISOR_W+1:0] divisor_ext;

    assign shifted     = {rem_i, bit_i};
    assign divisor_ext = {2'b00, divisor_i};

    // Keep the difference when the divisor fits, otherwise restore the shifted value
    always_comb begin
        q_bit_o = (shifted >= divisor_ext);
        rem_o   = q_bit_o ? RW'(shifted - divisor_ext) : shifted[DIVISOR_W:0];
    end

endmodule

// File: rtl/muladd_inverse_div.sv
// rtl/muladd_inverse_div.sv - sequential restoring divider recovering a and c from d = a*b + c
module muladd_inverse_div
    import muladd_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [DIVIDEND_W-1:0] d_i,
    input  logic [DIVISOR_W-1:0]  b_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [DIVIDEND_W-1:0] q_o,
    output logic [DIVISOR_W-1:0]  r_o,
    output logic                  dbz_o
);

    div_state_t state_q, state_d;

    logic [DIVIDEND_W-1:0] q_q;
    logic [DIVISOR_W:0]    rem_q;
    logic [DIVISOR_W-1:0]  b_q;
    logic [CNT_W-1:0]      cnt_q;
    logic                  dbz_q;

    logic                  accept;
    logic [DIVISOR_W:0]    rem_next;
    logic                  q_bit;

    assign accept = in_valid_i && in_ready_o;

    // The dividend MSB feeds the remainder while the quotient bit enters at the LSB
    div_step u_div_step (
        .rem_i     (rem_q),
        .bit_i     (q_q[DIVIDEND_W-1]),
        .divisor_i (b_q),
        .rem_o     (rem_next),
        .q_bit_o   (q_bit)
    );

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a zero divisor skips the iterations entirely
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (in_valid_i) begin
                    state_d = (b_i == '0) ? DONE : BUSY;
                end
            end
            BUSY: begin
                if (cnt_q == LAST_CNT) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs decoded from the state register only
    always_comb begin
        in_ready_o  = (state_q == IDLE);
        out_valid_o = (state_q == DONE);
    end

    // Datapath: load on accept, iterate in BUSY, hold otherwise so results stay stable under back-pressure
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            q_q   <= '0;
            rem_q <= '0;
            b_q   <= '0;
            cnt_q <= '0;
            dbz_q <= 1'b0;
        end else if (accept) begin
            b_q   <= b_i;
            rem_q <= '0;
            cnt_q <= '0;
            if (b_i == '0) begin
                q_q   <= DBZ_QUOTIENT;
                dbz_q <= 1'b1;
            end else begin
                q_q   <= d_i;
                dbz_q <= 1'b0;
            end
        end else if (state_q == BUSY) begin
            q_q   <= {q_q[DIVIDEND_W-2:0], q_bit};
            rem_q <= rem_next;
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Remainder is always below the divisor, so the top bit is dropped
    assign q_o   = q_q;
    assign r_o   = rem_q[DIVISOR_W-1:0];
    assign dbz_o = dbz_q;

endmodule

// File: tb/tb_muladd_inverse_div.sv
// tb/tb_muladd_inverse_div.sv - self-checking bench for muladd_inverse_div against an arithmetic model
module tb_muladd_inverse_div;
    import muladd_pkg::*;

    logic                  clk_i = 1'b0;
    logic                  rst_ni;
    logic                  in_valid_i;
    logic                  in_ready_o;
    logic [DIVIDEND_W-1:0] d_i;
    logic [DIVISOR_W-1:0]  b_i;
    logic                  out_valid_o;
    logic                  out_ready_i;
    logic [DIVIDEND_W-1:0] q_o;
    logic [DIVISOR_W-1:0]  r_o;
    logic                  dbz_o;

    int tests_run = 0;
    int tests_failed = 0;

    muladd_inverse_div dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .d_i         (d_i),
        .b_i         (b_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .q_o         (q_o),
        .r_o         (r_o),
        .dbz_o       (dbz_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, 32'(in_ready_o), 32'd1);
        check({tag, "_valid"}, 32'(out_valid_o), 32'd0);
        check({tag, "_q"}, 32'(q_o), 32'd0);
        check({tag, "_r"}, 32'(r_o), 32'd0);
        check({tag, "_dbz"}, 32'(dbz_o), 32'd0);
    endtask

    // One full transaction: issue, await result, optional back-pressure, consume
    task automatic run_op(input logic [15:0] d, input logic [7:0] b, input int hold,
                          input bit early_ready, input bit wiggle);
        int wait_n;
        int cyc;
        int exp_q;
        int exp_r;
        int exp_dbz;
        int exp_lat;
        wait_n = 0;
        while (!in_ready_o && wait_n < 50) begin
            @(posedge clk_i); #1;
            wait_n++;
        end
        check("ready_wait", 32'(in_ready_o), 32'd1);

        if (b == 0) begin
            exp_q = 32'hFFFF; exp_r = 0; exp_dbz = 1; exp_lat = 0;
        end else begin
            exp_q = int'(d) / int'(b); exp_r = int'(d) % int'(b); exp_dbz = 0; exp_lat = DIVIDEND_W;
        end

        d_i = d; b_i = b; in_valid_i = 1'b1; out_ready_i = early_ready;
        @(posedge clk_i); #1;
        in_valid_i = 1'b0;

        cyc = 0;
        while (!out_valid_o && cyc < 40) begin
            if (wiggle && cyc == 5) begin
                d_i = 16'($urandom); b_i = 8'($urandom); in_valid_i = 1'b1;
            end
            if (wiggle && cyc == 10) in_valid_i = 1'b0;
            @(posedge clk_i); #1;
            cyc++;
        end
        in_valid_i = 1'b0;
        check("latency", 32'(cyc), 32'(exp_lat));
        check("q", 32'(q_o), 32'(exp_q));
        check("r", 32'(r_o), 32'(exp_r));
        check("dbz", 32'(dbz_o), 32'(exp_dbz));

        if (!early_ready) begin
            for (int i = 0; i < hold; i++) begin
                @(posedge clk_i); #1;
                check("hold_valid", 32'(out_valid_o), 32'd1);
                check("hold_ready", 32'(in_ready_o), 32'd0);
                check("hold_q", 32'(q_o), 32'(exp_q));
                check("hold_r", 32'(r_o), 32'(exp_r));
                check("hold_dbz", 32'(dbz_o), 32'(exp_dbz));
            end
            out_ready_i = 1'b1;
        end
        @(posedge clk_i); #1;
        out_ready_i = 1'b0;
        check("valid_drop", 32'(out_valid_o), 32'd0);
        check("ready_back", 32'(in_ready_o), 32'd1);
    endtask

    initial begin
        rst_ni = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0; d_i = '0; b_i = '0;
        repeat (3) @(posedge clk_i);
        #1;
        check_reset_outputs("rst");
        rst_ni = 1'b1;
        @(posedge clk_i); #1;

        run_op(16'h0041, 8'h08, 0, 1'b0, 1'b0);
        run_op(16'h001A, 8'h05, 0, 1'b0, 1'b0);
        run_op(16'h0000, 8'h03, 0, 1'b1, 1'b0);
        run_op(16'hFFFF, 8'h01, 0, 1'b0, 1'b0);
        run_op(16'hFFFF, 8'hFF, 0, 1'b0, 1'b0);
        run_op(16'h00FE, 8'hFF, 0, 1'b0, 1'b0);
        run_op(16'h1234, 8'h00, 0, 1'b0, 1'b0);
        run_op(16'h1234, 8'h00, 2, 1'b1, 1'b0);
        run_op(16'hBEEF, 8'h2D, 10, 1'b0, 1'b0);
        run_op(16'h7A31, 8'h13, 0, 1'b0, 1'b1);

        // Abort mid-operation with an asynchronous reset
        d_i = 16'h1234; b_i = 8'h11; in_valid_i = 1'b1;
        @(posedge clk_i); #1;
        in_valid_i = 1'b0;
        repeat (8) @(posedge clk_i);
        #2;
        rst_ni = 1'b0;
        #1;
        check_reset_outputs("abort");
        repeat (2) @(posedge clk_i);
        #1;
        check_reset_outputs("abort_hold");
        rst_ni = 1'b1;
        @(posedge clk_i); #1;
        check("abort_no_result", 32'(out_valid_o), 32'd0);
        run_op(16'h0064, 8'h07, 0, 1'b0, 1'b0);

        for (int k = 0; k < 20; k++) begin
            logic [15:0] rd;
            logic [7:0]  rb;
            rd = 16'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            run_op(rd, rb, int'($urandom_range(0, 3)), 1'($urandom), 1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
